// File: rtl/step_counter.sv
// Step sequencer for the iterative multiply/divide datapath.
// Walks an index through LIMIT steps, gated by en, with abort, done and err pulses.
module step_counter #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 32,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if ((LIMIT < 1) || (longint'(LIMIT) > (longint'(1) << WIDTH))) begin : g_limit_check
    $error("step_counter: LIMIT must lie in 1..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] FIRST_IDX = DOWN ? WIDTH'(LIMIT - 1) : '0;
  localparam logic [WIDTH-1:0] FINAL_IDX = DOWN ? '0 : WIDTH'(LIMIT - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          count_next = FIRST_IDX;
        end
      end
      RUN: begin
        // A start during a run is only reported; it never queues another run.
        err_next = start;
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (en && (count_reg == FINAL_IDX)) begin
          state_next = IDLE;
          count_next = '0;
          done_next  = 1'b1;
        end else if (en) begin
          count_next = DOWN ? (count_reg - WIDTH'(1)) : (count_reg + WIDTH'(1));
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign count = count_reg;
  assign busy  = (state_reg == RUN);
  assign done  = done_reg;
  assign err   = err_reg;
  assign last  = (state_reg == RUN) && en && (count_reg == FINAL_IDX);

endmodule

// File: tb/tb_step_counter.sv
// Randomized bench: four step_counter configurations share one stimulus stream
// and are each compared against a step-count model every cycle.
module tb_step_counter;

  localparam int NCFG = 4;
  localparam int WID[NCFG] = '{6, 3, 6, 6};
  localparam int LIM[NCFG] = '{32, 5, 1, 64};
  localparam int DN [NCFG] = '{0, 1, 0, 0};

  logic clk = 1'b0;
  logic clr, start, en, abort;

  logic [5:0] cnt_w  [NCFG];
  logic       last_w [NCFG];
  logic       busy_w [NCFG];
  logic       done_w [NCFG];
  logic       err_w  [NCFG];

  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < NCFG; gi++) begin : g_dut
    logic [WID[gi]-1:0] c;
    step_counter #(
      .WIDTH(WID[gi]),
      .LIMIT(LIM[gi]),
      .DOWN (DN[gi] != 0)
    ) u_dut (
      .clk  (clk),
      .clr  (clr),
      .start(start),
      .en   (en),
      .abort(abort),
      .count(c),
      .last (last_w[gi]),
      .busy (busy_w[gi]),
      .done (done_w[gi]),
      .err  (err_w[gi])
    );
    assign cnt_w[gi] = 6'(c);
  end

  // Model: a run is "active" with "steps" en-qualified cycles completed so far.
  int m_active [NCFG];
  int m_steps  [NCFG];
  int m_cnt    [NCFG];
  int m_done   [NCFG];
  int m_err    [NCFG];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int step_index(input int k, input int s);
    return (DN[k] != 0) ? (LIM[k] - 1 - s) : s;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < NCFG; k++) begin
      if (!clr) begin
        m_active[k] = 0; m_steps[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_err[k] = 0;
      end else begin
        m_done[k] = 0;
        m_err[k]  = 0;
        if (m_active[k] == 0) begin
          if (start) begin
            m_active[k] = 1;
            m_steps[k]  = 0;
            m_cnt[k]    = step_index(k, 0);
          end
        end else begin
          m_err[k] = start ? 1 : 0;
          if (abort) begin
            m_active[k] = 0;
            m_cnt[k]    = 0;
          end else if (en) begin
            m_steps[k]++;
            if (m_steps[k] == LIM[k]) begin
              m_active[k] = 0;
              m_done[k]   = 1;
              m_cnt[k]    = 0;
            end else begin
              m_cnt[k] = step_index(k, m_steps[k]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = i / 1000;
      if (i < 3) begin
        clr = 1'b0; start = 1'b1; en = 1'b1; abort = 1'b1;
      end else if (phase == 0) begin
        // Back-to-back full runs: start-while-busy, start in the done cycle.
        clr   = ($urandom % 400) != 0;
        start = ($urandom % 4) == 0;
        en    = 1'b1;
        abort = 1'b0;
      end else if (phase == 1) begin
        // en toggling every cycle, occasional abort.
        clr   = ($urandom % 400) != 0;
        start = ($urandom % 8) == 0;
        en    = i[0];
        abort = ($urandom % 200) == 0;
      end else begin
        clr   = ($urandom % 300) != 0;
        start = ($urandom % 6) == 0;
        en    = ($urandom % 4) != 0;
        abort = ($urandom % 150) == 0;
      end

      @(negedge clk);
      if (i >= 3) begin
        for (int k = 0; k < NCFG; k++)
          check($sformatf("c%0d.last", k), int'(last_w[k]),
                (m_active[k] != 0 && en && m_steps[k] == LIM[k] - 1) ? 1 : 0);
      end

      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("c%0d.count", k), int'(cnt_w[k]), m_cnt[k]);
        check($sformatf("c%0d.busy", k), int'(busy_w[k]), m_active[k]);
        check($sformatf("c%0d.done", k), int'(done_w[k]), m_done[k]);
        check($sformatf("c%0d.err", k), int'(err_w[k]), m_err[k]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
